// File: rtl/mmio_bridge_hs.sv
// rtl/mmio_bridge_hs.sv - CPU data-port bridge: zero-wait DRAM pass-through plus handshaked peripheral window
// Optional feature macro BRIDGE_ERR_CNT_EN: saturating error counter decoded at PERI_BASE+12'hFFC.
module mmio_bridge_hs #(
  parameter int          NUM_PERI  = 4,
  parameter logic [31:0] PERI_BASE = 32'hFFFF_F000,
  parameter int          SLOT_LSB  = 3,
  parameter int          TIMEOUT   = 16
) (
  input  logic                    clk_from_cpu,
  input  logic                    rst_from_cpu,
  input  logic                    req_from_cpu,
  input  logic [31:0]             addr_from_cpu,
  input  logic [3:0]              we_from_cpu,
  input  logic [31:0]             wdata_from_cpu,
  output logic [31:0]             rdata_to_cpu,
  output logic                    stall_to_cpu,
  output logic                    err_to_cpu,
  output logic [31:0]             addr_to_dram,
  output logic [3:0]              we_to_dram,
  output logic [31:0]             wdata_to_dram,
  input  logic [31:0]             rdata_from_dram,
  output logic [NUM_PERI-1:0]     peri_sel,
  output logic [31:0]             peri_addr,
  output logic [3:0]              peri_we,
  output logic [31:0]             peri_wdata,
  input  logic [32*NUM_PERI-1:0]  peri_rdata,
  input  logic [NUM_PERI-1:0]     peri_ack
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         rdata_r;
  logic                err_r;
  logic [3:0]          idx_r;

  logic                peri_hit;
  logic                high_set;
  logic                idx_mapped;
  logic                cnt_hit;
  logic                accept;
  logic [3:0]          idx;
  logic [NUM_PERI-1:0] sel_dec;
  logic                ack_sel;
  logic [31:0]         rdata_sel;
  logic [15:0]         errcnt_val;

  assign addr_to_dram  = addr_from_cpu;
  assign wdata_to_dram = wdata_from_cpu;

  assign peri_hit   = (addr_from_cpu[31:12] == PERI_BASE[31:12]);
  assign idx        = addr_from_cpu[SLOT_LSB +: 4];
  assign high_set   = ((addr_from_cpu[11:0] >> (SLOT_LSB + 4)) != 12'd0);
  assign idx_mapped = ({28'd0, idx} < $unsigned(NUM_PERI)) && !high_set;
  assign accept     = (state == S_IDLE) && req_from_cpu && peri_hit;

  // Decode of the incoming index and mux of the channel latched for this access.
  always_comb begin
    sel_dec   = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_PERI; i++) begin
      if (idx == 4'(i)) sel_dec[i] = 1'b1;
      if (idx_r == 4'(i)) begin
        ack_sel   = peri_ack[i];
        rdata_sel = peri_rdata[32*i +: 32];
      end
    end
  end

`ifdef BRIDGE_ERR_CNT_EN
  logic [15:0] errcnt;

  assign cnt_hit    = peri_hit && (addr_from_cpu[11:0] == 12'hFFC);
  assign errcnt_val = errcnt;

  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) begin
      errcnt <= '0;
    end else if (accept && cnt_hit && (we_from_cpu != 4'd0)) begin
      errcnt <= '0;
    end else if ((state == S_DONE) && err_r && (errcnt != 16'hFFFF)) begin
      errcnt <= errcnt + 16'd1;
    end
  end
`else
  assign cnt_hit    = 1'b0;
  assign errcnt_val = 16'h0;
`endif

  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) state <= S_IDLE;
    else              state <= state_nx;
  end

  // Stall is forced low during reset so an abandoned access releases the CPU at once.
  always_comb begin
    state_nx     = state;
    stall_to_cpu = 1'b0;
    err_to_cpu   = 1'b0;
    rdata_to_cpu = rdata_from_dram;
    we_to_dram   = 4'd0;
    case (state)
      S_IDLE: begin
        if (req_from_cpu && !peri_hit) we_to_dram = we_from_cpu;
        if (accept) begin
          stall_to_cpu = !rst_from_cpu;
          state_nx     = (idx_mapped && !cnt_hit) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        stall_to_cpu = !rst_from_cpu;
        rdata_to_cpu = rdata_r;
        if (ack_sel || (cnt == CNT_LAST)) state_nx = S_DONE;
      end
      S_DONE: begin
        rdata_to_cpu = rdata_r;
        err_to_cpu   = err_r;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) begin
      cnt        <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      idx_r      <= '0;
      peri_sel   <= '0;
      peri_addr  <= '0;
      peri_we    <= '0;
      peri_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            peri_addr  <= addr_from_cpu;
            peri_we    <= we_from_cpu;
            peri_wdata <= wdata_from_cpu;
            idx_r      <= idx;
            cnt        <= '0;
            if (cnt_hit) begin
              rdata_r <= {16'h0, errcnt_val};
              err_r   <= 1'b0;
            end else if (!idx_mapped) begin
              rdata_r <= 32'hFFFF_FFFF;
              err_r   <= 1'b1;
            end else begin
              peri_sel <= sel_dec;
            end
          end
        end
        S_WAIT: begin
          // An ack in the final timeout cycle still counts as a normal completion.
          if (ack_sel) begin
            rdata_r  <= rdata_sel;
            err_r    <= 1'b0;
            peri_sel <= '0;
          end else if (cnt == CNT_LAST) begin
            rdata_r  <= 32'hFFFF_FFFF;
            err_r    <= 1'b1;
            peri_sel <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge_hs.sv
// tb/tb_mmio_bridge_hs.sv - randomized self-checking bench for mmio_bridge_hs against a transaction-level model
module tb_mmio_bridge_hs;

  localparam int NUM_PERI = 4;
  localparam int TIMEOUT  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req;
  logic [31:0]            addr;
  logic [3:0]             we;
  logic [31:0]            wdata;
  logic [31:0]            rdata_to_cpu;
  logic                   stall_to_cpu;
  logic                   err_to_cpu;
  logic [31:0]            addr_to_dram;
  logic [3:0]             we_to_dram;
  logic [31:0]            wdata_to_dram;
  logic [31:0]            rdata_from_dram;
  logic [NUM_PERI-1:0]    peri_sel;
  logic [31:0]            peri_addr;
  logic [3:0]             peri_we;
  logic [31:0]            peri_wdata;
  logic [32*NUM_PERI-1:0] peri_rdata;
  logic [NUM_PERI-1:0]    peri_ack;

  int checks = 0;
  int errors = 0;
  int model_errcnt = 0;

  always #5 clk = ~clk;

  mmio_bridge_hs #(
    .NUM_PERI (NUM_PERI),
    .PERI_BASE(32'hFFFF_F000),
    .SLOT_LSB (3),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_from_cpu   (clk),
    .rst_from_cpu   (rst),
    .req_from_cpu   (req),
    .addr_from_cpu  (addr),
    .we_from_cpu    (we),
    .wdata_from_cpu (wdata),
    .rdata_to_cpu   (rdata_to_cpu),
    .stall_to_cpu   (stall_to_cpu),
    .err_to_cpu     (err_to_cpu),
    .addr_to_dram   (addr_to_dram),
    .we_to_dram     (we_to_dram),
    .wdata_to_dram  (wdata_to_dram),
    .rdata_from_dram(rdata_from_dram),
    .peri_sel       (peri_sel),
    .peri_addr      (peri_addr),
    .peri_we        (peri_we),
    .peri_wdata     (peri_wdata),
    .peri_rdata     (peri_rdata),
    .peri_ack       (peri_ack)
  );

  // One CPU access from issue to commit; expectations come from the address map and ack timing alone.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                        input logic [31:0] dram_val, input int ack_at, input logic [31:0] ack_val,
                        input bit noise, input string name);
    bit          is_peri, mapped, is_cnt, chk_rd, done, sel_bad;
    int          idx, exp_stall, stalls, k;
    logic        exp_err, got_err;
    logic [31:0] exp_rd, got_rd;
    logic [3:0]  onehot, got_sel, got_wed;
    is_peri = (a[31:12] == 20'hFFFFF);
    idx     = int'(a[6:3]);
    mapped  = is_peri && (idx < NUM_PERI) && (a[11:7] == 5'd0);
    is_cnt  = 1'b0;
`ifdef BRIDGE_ERR_CNT_EN
    is_cnt  = is_peri && (a[11:0] == 12'hFFC);
`endif
    onehot  = mapped ? 4'(1 << idx) : 4'd0;
    if (!is_peri) begin
      exp_stall = 0; exp_err = 1'b0; exp_rd = dram_val;
    end else if (is_cnt) begin
      exp_stall = 1; exp_err = 1'b0; exp_rd = {16'h0, 16'(model_errcnt)};
    end else if (!mapped) begin
      exp_stall = 1; exp_err = 1'b1; exp_rd = 32'hFFFF_FFFF;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      exp_stall = 1 + ack_at; exp_err = 1'b0; exp_rd = ack_val;
    end else begin
      exp_stall = 1 + TIMEOUT; exp_err = 1'b1; exp_rd = 32'hFFFF_FFFF;
    end
    chk_rd = !is_peri || exp_err || (w == 4'd0);

    req = 1'b1; addr = a; we = w; wdata = wd; rdata_from_dram = dram_val;
    stalls = 0; done = 1'b0; sel_bad = 1'b0; k = 0;
    got_rd = 'x; got_err = 1'bx; got_sel = 'x; got_wed = 'x;
    while (!done && k < 64) begin
      peri_ack = noise ? (4'($urandom) & ~onehot) : 4'd0;
      if (noise && k == 0) peri_ack = 4'($urandom);
      for (int c = 0; c < NUM_PERI; c++) peri_rdata[32*c +: 32] = $urandom;
      if (mapped && k >= 1 && k == ack_at) begin
        peri_ack = peri_ack | onehot;
        peri_rdata[32*idx +: 32] = ack_val;
      end
      @(negedge clk);
      if (stall_to_cpu === 1'b1) begin
        stalls++;
        if (k == 0) begin
          if (peri_sel !== 4'd0 || we_to_dram !== 4'd0) sel_bad = 1'b1;
        end else if (peri_sel !== onehot || peri_addr !== a || peri_we !== w || peri_wdata !== wd) begin
          sel_bad = 1'b1;
        end
        @(posedge clk); #1;
        k++;
      end else begin
        done    = 1'b1;
        got_rd  = rdata_to_cpu;
        got_err = err_to_cpu;
        got_sel = peri_sel;
        got_wed = we_to_dram;
      end
    end

    checks++;
    if (!done) begin errors++; $display("FAIL %s complete: got no commit within 64 cycles, required commit", name); end
    checks++;
    if (stalls != exp_stall) begin errors++; $display("FAIL %s stall_cycles: got %0d required %0d", name, stalls, exp_stall); end
    checks++;
    if (got_err !== exp_err) begin errors++; $display("FAIL %s err: got %b required %b", name, got_err, exp_err); end
    if (chk_rd) begin
      checks++;
      if (got_rd !== exp_rd) begin errors++; $display("FAIL %s rdata: got %h required %h", name, got_rd, exp_rd); end
    end
    checks++;
    if (got_sel !== 4'd0) begin errors++; $display("FAIL %s done_sel: got %b required 0000", name, got_sel); end
    checks++;
    if (got_wed !== (is_peri ? 4'd0 : w)) begin errors++; $display("FAIL %s we_to_dram: got %b required %b", name, got_wed, (is_peri ? 4'd0 : w)); end
    checks++;
    if (sel_bad) begin errors++; $display("FAIL %s sel_during_stall: got wrong sel/addr/we/wdata, required one-hot %b with latched request", name, onehot); end

    if (done && exp_err && model_errcnt < 16'hFFFF) model_errcnt++;
    if (is_cnt && w != 4'd0) model_errcnt = 0;

    @(posedge clk); #1;
    req = 1'b0; peri_ack = '0;
    @(negedge clk);
    checks++;
    if (err_to_cpu !== 1'b0 || stall_to_cpu !== 1'b0) begin
      errors++; $display("FAIL %s after_commit: got err=%b stall=%b required 0 0", name, err_to_cpu, stall_to_cpu);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; addr = '0; we = '0; wdata = '0;
    rdata_from_dram = '0; peri_rdata = '0; peri_ack = '0;
    model_errcnt = 0;
    @(negedge clk);
    checks++;
    if (stall_to_cpu !== 1'b0 || err_to_cpu !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got stall=%b err=%b required 0 0", stall_to_cpu, err_to_cpu);
    end
    checks++;
    if (peri_sel !== 4'd0 || peri_we !== 4'd0 || peri_addr !== 32'd0 || peri_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_peri: got sel=%b we=%b addr=%h wdata=%h required all zero", peri_sel, peri_we, peri_addr, peri_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dram();
    access(32'h0000_0100, 4'd0, 32'h0, 32'h1234_5678, 0, 32'h0, 1'b0, "dram_read");
    access(32'h8000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 32'h0, 1'b0, "dram_write");
  endtask

  task automatic test_peri_read();
    access(32'hFFFF_F010, 4'd0, 32'h0, 32'h1111_1111, 1, 32'hCAFE_0002, 1'b0, "peri_read_ch2");
  endtask

  task automatic test_peri_write();
    access(32'hFFFF_F008, 4'b0001, 32'h0000_00A5, 32'h0, 3, 32'h0, 1'b0, "peri_write_ch1");
  endtask

  task automatic test_timeout();
    access(32'hFFFF_F000, 4'd0, 32'h0, 32'h0, 0, 32'h0, 1'b0, "timeout_ch0");
    access(32'hFFFF_F000, 4'd0, 32'h0, 32'h0, TIMEOUT, 32'h5555_AAAA, 1'b0, "ack_at_last");
    access(32'hFFFF_F018, 4'd0, 32'h0, 32'h0, TIMEOUT + 1, 32'h7777_0000, 1'b0, "ack_in_done");
  endtask

  task automatic test_unmapped();
`ifdef BRIDGE_ERR_CNT_EN
    access(32'hFFFF_FFFC, 4'b1111, 32'h0, 32'h0, 0, 32'h0, 1'b0, "errcnt_clear");
`endif
    access(32'hFFFF_F040, 4'd0, 32'h0, 32'h0, 1, 32'h0, 1'b0, "unmapped_idx8");
    access(32'hFFFF_F080, 4'd0, 32'h0, 32'h0, 1, 32'h0, 1'b0, "unmapped_high");
    access(32'hFFFF_FFFC, 4'd0, 32'h0, 32'h0, 1, 32'h0, 1'b0, "addr_ffc_read");
  endtask

  task automatic test_reset_in_wait();
    req = 1'b1; addr = 32'hFFFF_F000; we = 4'd0; wdata = '0; peri_ack = '0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (peri_sel !== 4'b0001 || stall_to_cpu !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre: got sel=%b stall=%b required 0001 1", peri_sel, stall_to_cpu);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (peri_sel !== 4'd0 || stall_to_cpu !== 1'b0 || err_to_cpu !== 1'b0) begin
      errors++; $display("FAIL rst_wait_drop: got sel=%b stall=%b err=%b required 0000 0 0", peri_sel, stall_to_cpu, err_to_cpu);
    end
    req = 1'b0;
    model_errcnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(32'h0000_2000, 4'd0, 32'h0, 32'hA5A5_5A5A, 0, 32'h0, 1'b0, "dram_after_reset");
  endtask

  task automatic test_random();
    int          kind;
    logic [31:0] a;
    logic [3:0]  w;
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 3));
      w    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      case (kind)
        0: begin
          a = $urandom;
          if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
        end
        1: a = {20'hFFFFF, 5'd0, 4'($urandom_range(0, NUM_PERI - 1)), 3'($urandom)};
        2: a = {20'hFFFFF, 12'($urandom)};
        default: a = 32'hFFFF_FFFC;
      endcase
      access(a, w, $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 2)), $urandom, 1'b1, "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, required finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dram();
    test_peri_read();
    test_peri_write();
    test_timeout();
    test_unmapped();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
